wb_exmem_arbiter: RTL

Two-master Wishbone arbiter that shares the single external-memory slave port (address window 0x38xx_xxxx) between the management SoC and an accelerator DMA master. It sits in the user project between the address decoder and the exmem slave. Arbitration is round-robin on whole bus cycles (cyc-level locking). A per-access timeout guarantees the owning master always receives an ack.

---
 rtl/wb_exmem_arbiter.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/wb_exmem_arbiter.sv
// Two-master Wishbone arbiter for the shared external-memory slave port.
// Round-robin on whole bus cycles, with a per-access timeout that forces an ack.
module wb_exmem_arbiter #(
  parameter int          TIMEOUT = 255,
  parameter logic [31:0] TO_DATA = 32'hDEAD_BEEF
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,

  input  logic        m0_cyc_i,
  input  logic        m0_stb_i,
  input  logic        m0_we_i,
  input  logic [3:0]  m0_sel_i,
  input  logic [31:0] m0_adr_i,
  input  logic [31:0] m0_dat_i,
  output logic        m0_ack_o,
  output logic [31:0] m0_dat_o,

  input  logic        m1_cyc_i,
  input  logic        m1_stb_i,
  input  logic        m1_we_i,
  input  logic [3:0]  m1_sel_i,
  input  logic [31:0] m1_adr_i,
  input  logic [31:0] m1_dat_i,
  output logic        m1_ack_o,
  output logic [31:0] m1_dat_o,

  output logic        s_cyc_o,
  output logic        s_stb_o,
  output logic        s_we_o,
  output logic [3:0]  s_sel_o,
  output logic [31:0] s_adr_o,
  output logic [31:0] s_dat_o,
  input  logic        s_ack_i,
  input  logic [31:0] s_dat_i,

  output logic [1:0]  grant_o,
  output logic        timeout_o,
  input  logic        clr_timeout_i
);

  localparam int            CW     = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TO_CNT = CW'(TIMEOUT);

  // One-hot encoding chosen so the state register doubles as grant_o.
  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] OWN0 = 2'b01;
  localparam logic [1:0] OWN1 = 2'b10;

  logic [1:0]    state, state_next;
  logic          last_q, last_next;
  logic [CW-1:0] cnt, cnt_next;
  logic          timeout_q, timeout_next;

  logic [1:0]  m_cyc;
  logic [1:0]  m_stb;
  logic [1:0]  m_we;
  logic [3:0]  m_sel [2];
  logic [31:0] m_adr [2];
  logic [31:0] m_wdat [2];
  logic [1:0]  m_req;
  logic [1:0]  m_ack;
  logic [31:0] m_rdat [2];

  logic own_sel;
  logic owned;
  logic own_cyc;
  logic own_stb;
  logic forced;

  assign m_cyc     = {m1_cyc_i, m0_cyc_i};
  assign m_stb     = {m1_stb_i, m0_stb_i};
  assign m_we      = {m1_we_i, m0_we_i};
  assign m_sel[0]  = m0_sel_i;
  assign m_sel[1]  = m1_sel_i;
  assign m_adr[0]  = m0_adr_i;
  assign m_adr[1]  = m1_adr_i;
  assign m_wdat[0] = m0_dat_i;
  assign m_wdat[1] = m1_dat_i;

  assign own_sel = state[1];
  assign owned   = |state;
  assign own_cyc = owned & m_cyc[own_sel];
  assign own_stb = owned & m_stb[own_sel];

  // A slave ack in the saturation cycle wins over the forced completion.
  assign forced = own_cyc & own_stb & ~s_ack_i & (cnt == TO_CNT);

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_master
      assign m_req[gi]  = m_cyc[gi] & m_stb[gi];
      assign m_ack[gi]  = state[gi] & (forced | s_ack_i);
      assign m_rdat[gi] = !state[gi] ? 32'h0 :
                          forced     ? TO_DATA : s_dat_i;
    end
  endgenerate

  assign m0_ack_o = m_ack[0];
  assign m1_ack_o = m_ack[1];
  assign m0_dat_o = m_rdat[0];
  assign m1_dat_o = m_rdat[1];

  assign s_cyc_o = own_cyc & ~forced;
  assign s_stb_o = own_stb & ~forced;
  assign s_we_o  = owned & m_we[own_sel];
  assign s_sel_o = owned ? m_sel[own_sel]  : 4'h0;
  assign s_adr_o = owned ? m_adr[own_sel]  : 32'h0;
  assign s_dat_o = owned ? m_wdat[own_sel] : 32'h0;

  assign grant_o   = state;
  assign timeout_o = timeout_q;

  always_comb begin
    state_next = state;
    last_next  = last_q;
    case (state)
      IDLE: begin
        if (m_req == 2'b11)
          state_next = last_q ? OWN0 : OWN1;
        else if (m_req[0])
          state_next = OWN0;
        else if (m_req[1])
          state_next = OWN1;
      end
      OWN0: begin
        if (!m_cyc[0]) begin
          last_next  = 1'b0;
          state_next = m_req[1] ? OWN1 : IDLE;
        end
      end
      OWN1: begin
        if (!m_cyc[1]) begin
          last_next  = 1'b1;
          state_next = m_req[0] ? OWN0 : IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Counts consecutive unacked strobe cycles of the current owner only.
  always_comb begin
    cnt_next = cnt;
    if (!own_cyc || !own_stb || s_ack_i || forced)
      cnt_next = '0;
    else if (cnt != TO_CNT)
      cnt_next = cnt + 1'b1;
  end

  always_comb begin
    timeout_next = timeout_q;
    if (forced)
      timeout_next = 1'b1;
    else if (clr_timeout_i)
      timeout_next = 1'b0;
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state     <= IDLE;
      last_q    <= 1'b1;
      cnt       <= '0;
      timeout_q <= 1'b0;
    end else begin
      state     <= state_next;
      last_q    <= last_next;
      cnt       <= cnt_next;
      timeout_q <= timeout_next;
    end
  end

endmodule
